fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write arbiter sharing one fifo write port among NUM_REQ producers.
//  Each producer has a valid/ready/data channel. The arbiter locks one owner for a burst
//  of up to BURST_MAX words, then rotates ownership. It drives fifo w_valid/data_in and
//  never writes while fifo_full=1. Sits between producer blocks and the fifo instance.
// PARAMETERS
//  WIDTH      32  data word width; equals the fifo WIDTH
//  NUM_REQ    4   number of requesters (>=2)
//  BURST_MAX  4   max consecutive words per grant (>=1)
// PORTS
//  clk        in   1              rising-edge clock
//  reset      in   1              async, active-high; clears all state
//  req_valid  in   NUM_REQ        per-requester word available
//  req_data   in   NUM_REQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH]
//  req_ready  out  NUM_REQ        one-hot or zero; word i accepted when req_valid[i]&req_ready[i]
//  fifo_full  in   1              from fifo; blocks writes
//  w_valid    out  1              fifo write strobe
//  data_in    out  WIDTH          fifo write data
//  grant_id   out  clog2(NUM_REQ) current owner index (valid while busy=1)
//  busy       out  1              1 in LOCK state
// BEHAVIOUR
//  - Reset: state=IDLE, rr_ptr=0, owner=0, burst_cnt=0. Outputs: req_ready=0, w_valid=0,
//    data_in=0, grant_id=0, busy=0.
//  - IDLE: if any req_valid, pick the first set bit searching rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
//    Register owner, burst_cnt=0, go to LOCK. No transfer in IDLE.
//    Arbitration latency is 1 cycle: first accept occurs at the earliest one cycle after valid.
//  - LOCK (combinational outputs):
//    - xfer = req_valid[owner] & !fifo_full
//    - req_ready[owner] = !fifo_full; all other req_ready bits = 0
//    - w_valid = xfer; data_in = req_data[owner] when xfer, else 0
//  - LOCK exit to IDLE, with rr_ptr=(owner+1) mod NUM_REQ:
//    (a) xfer and burst_cnt==BURST_MAX-1 (burst done);
//    (b) req_valid[owner]==0 (owner dropped or finished).
//    Otherwise stay in LOCK; burst_cnt increments on each xfer.
//  - fifo_full=1 in LOCK: hold owner and burst_cnt, no write, no timeout. The owner keeps the
//    grant until full clears, even while others wait.
//  - Requester rule: once req_valid is high, hold it and the data stable until accepted.
//    A requester that drops valid mid-burst loses the grant under (b); this is not an error.
//  - Fairness: with all requesters valid, grant order is 0,1,...,NUM_REQ-1,0,...; each grant
//    carries BURST_MAX words unless the fifo stalls.
//  - Wrap: rr_ptr and the search index wrap modulo NUM_REQ (non-power-of-2 NUM_REQ supported).
//    burst_cnt is clog2(BURST_MAX+1) bits wide and never wraps.
//  - Reset asserted mid-burst: immediate return to reset values; a partially written burst
//    is not replayed.
//  - Throughput: BURST_MAX words per (BURST_MAX+1) cycles when never full.
// STRUCTURE
//  - Shared package fifo_pkg:
//    - state encoding localparams ST_IDLE=1'b0, ST_LOCK=1'b1
//    - clog2 function for index and counter widths
//  - One sub-module rr_pick (combinational): inputs req[NUM_REQ], ptr; outputs any, idx.
//    It is reused by future read-side schedulers. Everything else is inline.
// TESTING
//  - Reset, then idle with all req_valid=0 -> w_valid=0, req_ready=0, busy=0 for 10 cycles;
//    fifo empty.
//  - Single requester 2 valid with words 0..9, BURST_MAX=4, no full -> 4 words, 1 IDLE cycle,
//    repeat. Fifo order is 0..9 and grant_id=2 throughout.
//  - All 4 valid, each with 8 tagged words -> grant order 0,1,2,3,0,1,2,3 with 4 words each.
//    No word lost or duplicated (scoreboard per requester).
//  - fifo_full forced high for 5 cycles mid-burst at burst_cnt=2 -> w_valid=0, owner held.
//    After release, exactly 2 more words from the same owner.
//  - Owner 1 drops valid after 1 word while 3 is valid -> IDLE next cycle, then grant to 3
//    (rr_ptr=2 search).
//  - Reset asserted during LOCK -> all outputs 0 asynchronously. After release, arbitration
//    restarts at requester 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo write-side (and future read-side) schedulers.
//   ST_IDLE / ST_LOCK : arbiter state encoding
//   clog2()           : ceil(log2(n)), never less than 1, for index/counter widths
package fifo_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_LOCK = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req : request vector
//   ptr : index where the search starts (must be < NUM_REQ)
//   any : at least one request set
//   idx : first set request at ptr, ptr+1, ... wrapping modulo NUM_REQ
module rr_pick
    import fifo_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]        req,
    input  logic [clog2(NUM_REQ)-1:0] ptr,
    output logic                      any,
    output logic [clog2(NUM_REQ)-1:0] idx
);

    localparam int IDX_W = clog2(NUM_REQ);

    // ptr + k is at most 2*NUM_REQ-2, so a single subtract wraps it; this
    // keeps non-power-of-2 requester counts correct.
    function automatic int wrap(input int a);
        return (a >= NUM_REQ) ? a - NUM_REQ : a;
    endfunction

    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any && req[wrap(int'(ptr) + k)]) begin
                any = 1'b1;
                idx = IDX_W'(wrap(int'(ptr) + k));
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one fifo write port among
// NUM_REQ valid/ready producers. One owner is locked for up to BURST_MAX words,
// then ownership rotates to the next requester.
//   clk, reset           : clock, async active-high reset
//   req_valid/req_data   : producer channels, requester i at [i*WIDTH +: WIDTH]
//   req_ready            : one-hot (owner only) or zero
//   fifo_full            : back-pressure from the fifo; no write while set
//   w_valid/data_in      : fifo write strobe and data
//   grant_id             : current owner (meaningful while busy)
//   busy                 : arbiter holds a grant
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NUM_REQ   = 4,
    parameter int BURST_MAX = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      w_valid,
    output logic [WIDTH-1:0]          data_in,
    output logic [clog2(NUM_REQ)-1:0] grant_id,
    output logic                      busy
);

    localparam int IDX_W = clog2(NUM_REQ);
    localparam int CNT_W = clog2(BURST_MAX + 1);

    logic             state, state_nx;
    logic [IDX_W-1:0] owner, owner_nx;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nx;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_nx;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             owner_valid, xfer, burst_done;
    logic [IDX_W-1:0] owner_inc;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign owner_valid = req_valid[owner];
    assign xfer        = (state == ST_LOCK) && owner_valid && !fifo_full;
    assign burst_done  = (burst_cnt == CNT_W'(BURST_MAX - 1));
    // Explicit wrap so non-power-of-2 NUM_REQ never yields an out-of-range pointer.
    assign owner_inc   = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            owner     <= owner_nx;
            rr_ptr    <= rr_ptr_nx;
            burst_cnt <= burst_cnt_nx;
        end
    end

    // Next state. A stalled fifo leaves every register untouched, so the
    // owner keeps its grant and remaining burst budget indefinitely.
    always_comb begin
        state_nx     = state;
        owner_nx     = owner;
        rr_ptr_nx    = rr_ptr;
        burst_cnt_nx = burst_cnt;
        if (state == ST_IDLE) begin
            if (pick_any) begin
                state_nx     = ST_LOCK;
                owner_nx     = pick_idx;
                burst_cnt_nx = '0;
            end
        end else begin
            if ((xfer && burst_done) || !owner_valid) begin
                state_nx  = ST_IDLE;
                rr_ptr_nx = owner_inc;
            end else if (xfer) begin
                burst_cnt_nx = burst_cnt + CNT_W'(1);
            end
        end
    end

    // Outputs: purely a function of the registered grant and live inputs.
    always_comb begin
        req_ready = '0;
        w_valid   = 1'b0;
        data_in   = '0;
        busy      = (state == ST_LOCK);
        grant_id  = owner;
        if (state == ST_LOCK) begin
            req_ready[owner] = !fifo_full;
            w_valid          = xfer;
            if (xfer) data_in = req_data[int'(owner)*WIDTH +: WIDTH];
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (WIDTH=32, NUM_REQ=4, BURST_MAX=4).
// A grant-level model (owner or none, words left in the grant, next search start)
// predicts every output each cycle; directed scenarios add literal expectations.
module tb_fifo_wr_arbiter;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int B  = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             fifo_full;
    logic             w_valid;
    logic [W-1:0]     data_in;
    logic [IW-1:0]    grant_id;
    logic             busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .BURST_MAX(B)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .w_valid   (w_valid),
        .data_in   (data_in),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Producers: per-requester word queues; valid while enabled and non-empty.
    logic [W-1:0] q[N][$];
    bit           en[N];
    logic [N-1:0] acc;

    // Fifo-side log of every written word.
    logic [W-1:0] lg_d[$];
    int           lg_g[$];
    int           lg_c[$];
    int           cyc = 0;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = en[i] && (q[i].size() > 0);
            req_data[i*W +: W] = req_valid[i] ? q[i][0] : '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (acc[i] && q[i].size() > 0) void'(q[i].pop_front());
        drive();
    endtask

    task automatic clear_log();
        lg_d.delete();
        lg_g.delete();
        lg_c.delete();
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++)
            if (en[i] && q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((pending() || busy) && n < maxc) begin
            step();
            n++;
        end
        chk("drain_timeout", n < maxc, 1);
        step();
    endtask

    task automatic wait_writes(input int cnt, input int maxc);
        int n;
        n = 0;
        while (lg_d.size() < cnt && n < maxc) begin
            step();
            n++;
        end
        chk("wait_writes_timeout", lg_d.size() >= cnt, 1);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        for (int i = 0; i < N; i++) q[i].delete();
        drive();
        repeat (2) step();
        reset = 1'b0;
    endtask

    // ---------------- behavioural model ----------------
    int           m_owner = -1;  // -1: no grant held
    int           m_left  = 0;   // words still allowed in this grant
    int           m_next  = 0;   // where the next search starts
    logic [N-1:0] e_rdy;
    logic         e_wv, xf;
    logic [W-1:0] e_d;

    function automatic int pick_first(input logic [N-1:0] v, input int s);
        for (int k = 0; k < N; k++)
            if (v[(s + k) % N]) return (s + k) % N;
        return -1;
    endfunction

    always @(negedge clk) begin
        cyc++;
        e_rdy = '0;
        e_wv  = 1'b0;
        e_d   = '0;
        xf    = 1'b0;
        if (reset) begin
            m_owner = -1;
            m_left  = 0;
            m_next  = 0;
        end else if (m_owner >= 0) begin
            e_rdy[m_owner] = !fifo_full;
            xf             = req_valid[m_owner] && !fifo_full;
            e_wv           = xf;
            if (xf) e_d = req_data[m_owner*W +: W];
        end
        chk("req_ready", req_ready, e_rdy);
        chk("w_valid", w_valid, e_wv);
        chk("data_in", data_in, e_d);
        chk("busy", busy, m_owner >= 0);
        if (reset) chk("grant_id_rst", grant_id, 0);
        else if (m_owner >= 0) chk("grant_id", grant_id, m_owner);
        if (!reset) begin
            if (w_valid) begin
                lg_d.push_back(data_in);
                lg_g.push_back(int'(grant_id));
                lg_c.push_back(cyc);
            end
            if (m_owner < 0) begin
                m_owner = pick_first(req_valid, m_next);
                m_left  = B;
            end else begin
                if (xf) m_left--;
                if (m_left == 0 || !req_valid[m_owner]) begin
                    m_next  = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end
        end
        acc = reset ? '0 : (req_valid & req_ready);
    end

    // ---------------- directed scenarios ----------------
    int sb[N];

    initial begin
        reset     = 1'b1;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) en[i] = 1'b0;
        drive();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_w_valid", w_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_grant_id", grant_id, 0);
        repeat (2) step();
        reset = 1'b0;

        // Idle: nothing requested for 10 cycles.
        clear_log();
        repeat (10) step();
        chk("idle_writes", lg_d.size(), 0);
        chk("idle_busy", busy, 0);

        // Single requester 2 with words 0..9.
        for (int k = 0; k < 10; k++) q[2].push_back(W'(k));
        en[2] = 1'b1;
        drive();
        drain(100);
        en[2] = 1'b0;
        chk("single_count", lg_d.size(), 10);
        if (lg_d.size() == 10) begin
            for (int k = 0; k < 10; k++) begin
                chk("single_data", lg_d[k], k);
                chk("single_grant", lg_g[k], 2);
            end
            chk("single_burst_span", lg_c[3] - lg_c[0], 3);
            chk("single_idle_gap", lg_c[4] - lg_c[3], 2);
            chk("single_tail", lg_c[9] - lg_c[8], 1);
        end

        // All four valid, 8 tagged words each; restart from pointer 0.
        apply_reset();
        clear_log();
        for (int i = 0; i < N; i++) begin
            sb[i] = 0;
            en[i] = 1'b1;
            for (int k = 0; k < 8; k++) q[i].push_back(W'((i << 8) | k));
        end
        drive();
        drain(200);
        chk("all_count", lg_d.size(), 32);
        if (lg_d.size() == 32) begin
            for (int k = 0; k < 32; k++) begin
                chk("all_grant_order", lg_g[k], (k / 4) % 4);
                chk("all_sb_data", lg_d[k], (lg_g[k] << 8) | sb[lg_g[k]]);
                sb[lg_g[k]]++;
            end
            for (int i = 0; i < N; i++) chk("all_sb_count", sb[i], 8);
            chk("all_throughput", lg_c[31] - lg_c[0], 38);
        end

        // fifo_full for 5 cycles once two words of a burst are written.
        for (int i = 0; i < N; i++) en[i] = 1'b0;
        clear_log();
        for (int k = 0; k < 4; k++) q[0].push_back(W'(32'h400 + k));
        en[0] = 1'b1;
        drive();
        wait_writes(2, 20);
        fifo_full = 1'b1;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("full_w_valid", w_valid, 0);
            chk("full_busy", busy, 1);
            chk("full_grant", grant_id, 0);
            chk("full_ready", req_ready, 0);
            step();
        end
        fifo_full = 1'b0;
        drain(50);
        en[0] = 1'b0;
        chk("full_count", lg_d.size(), 4);
        if (lg_d.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("full_data", lg_d[k], 32'h400 + k);
                chk("full_owner", lg_g[k], 0);
            end
            chk("full_stall_gap", lg_c[2] - lg_c[1], 6);
        end

        // Owner 1 runs dry after one word while 3 waits.
        clear_log();
        q[1].push_back(32'h510);
        q[3].push_back(32'h530);
        q[3].push_back(32'h531);
        en[1] = 1'b1;
        en[3] = 1'b1;
        drive();
        drain(50);
        en[1] = 1'b0;
        en[3] = 1'b0;
        chk("drop_count", lg_d.size(), 3);
        if (lg_d.size() == 3) begin
            chk("drop_g0", lg_g[0], 1);
            chk("drop_g1", lg_g[1], 3);
            chk("drop_g2", lg_g[2], 3);
            chk("drop_d1", lg_d[1], 32'h530);
            chk("drop_gap", lg_c[1] - lg_c[0], 3);
        end

        // Reset inside the second grant to requester 2 (pointer is then 3).
        clear_log();
        for (int k = 0; k < 6; k++) q[2].push_back(W'(32'h620 + k));
        en[2] = 1'b1;
        drive();
        wait_writes(5, 30);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_grant", grant_id, 2);
        #2 reset = 1'b1;
        #1;
        chk("async_busy", busy, 0);
        chk("async_w_valid", w_valid, 0);
        chk("async_req_ready", req_ready, 0);
        chk("async_data_in", data_in, 0);
        chk("async_grant_id", grant_id, 0);
        for (int i = 0; i < N; i++) q[i].delete();
        drive();
        repeat (2) step();
        reset = 1'b0;
        clear_log();
        for (int i = 0; i < N; i++) begin
            en[i] = 1'b1;
            for (int k = 0; k < 2; k++) q[i].push_back(W'(32'h700 | (i << 4) | k));
        end
        drive();
        drain(100);
        chk("post_rst_count", lg_d.size(), 8);
        if (lg_d.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                chk("post_rst_grant", lg_g[k], k / 2);
                chk("post_rst_data", lg_d[k], 32'h700 | ((k / 2) << 4) | (k % 2));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
